// File: rtl/alu_demo_sched.sv
// ---------------------------------------------------------------------------
// alu_demo_sched
//
// Scheduler for the shared add/subtract accumulator datapath of the calculator.
// Two requesters share the datapath:
//   * a timed four-step demo program (add-RC, sub-RC, add, sub), where every
//     WORD and RESULT phase is held for DWELL_TICKS pulses of a slow `tick`
//     strobe so the display stays readable;
//   * manual button operations (single add/subtract or accumulator clear).
//
// Parameters
//   DWELL_TICKS  tick pulses each WORD / RESULT phase is held (>= 1)
//
// Build option
//   ALU_DEMO_SCHED_LOOP_EN  when defined, the demo restarts from step 0 after
//                           step 3 as long as `demo` stays high; when not
//                           defined, the scheduler parks in DONE until
//                           `demo` falls.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   tick      in   one-cycle pacing strobe from the clock divider
//   demo      in   level, demo program requested
//   man_req   in   pulse, execute one manual operation
//   man_sub   in   manual op select (0 add, 1 subtract), sampled with man_req
//   man_rc    in   manual ripple-carry select, sampled with man_req
//   man_clr   in   pulse, clear the accumulator
//   d_clr     out  accumulator clear
//   d_en      out  accumulator load enable (single-cycle pulse)
//   d_sub     out  subtract select
//   d_RC      out  ripple-carry mode select
//   word_sel  out  word shown on the display while disp_sel = 1
//   disp_sel  out  1 = show word, 0 = show accumulator
//   busy      out  high whenever the scheduler is not idle
//   step_idx  out  current demo step 0..3
//   man_drop  out  one-cycle pulse when a manual request is discarded
// ---------------------------------------------------------------------------
module alu_demo_sched #(
    parameter int DWELL_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       demo,
    input  logic       man_req,
    input  logic       man_sub,
    input  logic       man_rc,
    input  logic       man_clr,
    output logic       d_clr,
    output logic       d_en,
    output logic       d_sub,
    output logic       d_RC,
    output logic [2:0] word_sel,
    output logic       disp_sel,
    output logic       busy,
    output logic [1:0] step_idx,
    output logic       man_drop
);

    localparam int            CW         = $clog2(DWELL_TICKS + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_TICKS - 1);
    localparam logic [CW-1:0] DWELL_ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WORD,
        ST_EXEC,
        ST_RESULT,
        ST_MAN_EXEC,
        ST_DONE
    } state_t;

    state_t        state_reg,   state_next;
    logic [1:0]    step_reg,    step_next;
    logic [CW-1:0] dwell_reg,   dwell_next;
    logic          armed_reg,   armed_next;
    logic          lat_sub_reg, lat_sub_next;
    logic          lat_rc_reg,  lat_rc_next;
    logic          drop_reg,    drop_next;

    // ------------------------------------------------------------------
    // Demo step table: steps 0/1 use ripple carry, odd steps subtract.
    // ------------------------------------------------------------------
    logic [3:0] tab_sub;
    logic [3:0] tab_rc;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_step_tab
            assign tab_sub[gi] = ((gi % 2) == 1) ? 1'b1 : 1'b0;
            assign tab_rc[gi]  = (gi < 2) ? 1'b1 : 1'b0;
        end
    endgenerate

    logic step_sub;
    logic step_rc;
    logic dwell_done;

    assign step_sub   = tab_sub[step_reg];
    assign step_rc    = tab_rc[step_reg];
    // A WORD/RESULT phase ends on the tick that completes the dwell count.
    assign dwell_done = tick && (dwell_reg == DWELL_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            step_reg    <= 2'd0;
            dwell_reg   <= '0;
            armed_reg   <= 1'b0;
            lat_sub_reg <= 1'b0;
            lat_rc_reg  <= 1'b0;
            drop_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            step_reg    <= step_next;
            dwell_reg   <= dwell_next;
            armed_reg   <= armed_next;
            lat_sub_reg <= lat_sub_next;
            lat_rc_reg  <= lat_rc_next;
            drop_reg    <= drop_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        step_next    = step_reg;
        dwell_next   = dwell_reg;
        armed_next   = armed_reg;
        lat_sub_next = lat_sub_reg;
        lat_rc_next  = lat_rc_reg;
        drop_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (demo) begin
                    state_next = ST_CLEAR;
                    step_next  = 2'd0;
                    armed_next = 1'b1;
                end else if (man_clr) begin
                    state_next = ST_CLEAR;
                    armed_next = 1'b0;
                end else if (man_req) begin
                    state_next   = ST_MAN_EXEC;
                    lat_sub_next = man_sub;
                    lat_rc_next  = man_rc;
                end
            end

            ST_CLEAR: begin
                // The clear has already been issued this cycle, so an
                // abort seen here simply returns to idle.
                if (armed_reg && demo) begin
                    state_next = ST_WORD;
                    dwell_next = '0;
                end else begin
                    state_next = ST_IDLE;
                    armed_next = 1'b0;
                    step_next  = 2'd0;
                end
            end

            ST_WORD: begin
                if (!demo) begin
                    state_next = ST_CLEAR;
                    armed_next = 1'b0;
                    step_next  = 2'd0;
                end else if (dwell_done) begin
                    state_next = ST_EXEC;
                end else if (tick) begin
                    dwell_next = dwell_reg + DWELL_ONE;
                end
            end

            ST_EXEC: begin
                // The load pulse always completes; an abort is taken after.
                if (!demo) begin
                    state_next = ST_CLEAR;
                    armed_next = 1'b0;
                    step_next  = 2'd0;
                end else begin
                    state_next = ST_RESULT;
                    dwell_next = '0;
                end
            end

            ST_RESULT: begin
                if (!demo) begin
                    state_next = ST_CLEAR;
                    armed_next = 1'b0;
                    step_next  = 2'd0;
                end else if (dwell_done) begin
                    if (step_reg != 2'd3) begin
                        state_next = ST_WORD;
                        step_next  = step_reg + 2'd1;
                        dwell_next = '0;
                    end else begin
`ifdef ALU_DEMO_SCHED_LOOP_EN
                        state_next = ST_CLEAR;
                        step_next  = 2'd0;
`else
                        state_next = ST_DONE;
`endif
                    end
                end else if (tick) begin
                    dwell_next = dwell_reg + DWELL_ONE;
                end
            end

            ST_MAN_EXEC: begin
                state_next = ST_IDLE;
            end

            ST_DONE: begin
                if (!demo) begin
                    state_next = ST_CLEAR;
                    armed_next = 1'b0;
                    step_next  = 2'd0;
                end
            end

            default: begin
                state_next = ST_IDLE;
                armed_next = 1'b0;
                step_next  = 2'd0;
            end
        endcase

        // Manual requests are only served from IDLE, and only when they win
        // arbitration there (demo > clear > operation).
        if (state_reg != ST_IDLE) begin
            drop_next = man_req | man_clr;
        end else if (demo) begin
            drop_next = man_req | man_clr;
        end else begin
            drop_next = man_clr & man_req;
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        d_clr    = 1'b0;
        d_en     = 1'b0;
        d_sub    = 1'b0;
        d_RC     = 1'b0;
        word_sel = 3'd0;
        disp_sel = 1'b0;
        busy     = (state_reg != ST_IDLE);

        case (state_reg)
            ST_CLEAR: begin
                d_clr = 1'b1;
            end
            ST_WORD: begin
                disp_sel = 1'b1;
                word_sel = {1'b0, step_reg};
                d_sub    = step_sub;
                d_RC     = step_rc;
            end
            ST_EXEC: begin
                d_en  = 1'b1;
                d_sub = step_sub;
                d_RC  = step_rc;
            end
            ST_RESULT: begin
                d_sub = step_sub;
                d_RC  = step_rc;
            end
            ST_MAN_EXEC: begin
                d_en  = 1'b1;
                d_sub = lat_sub_reg;
                d_RC  = lat_rc_reg;
            end
            default: begin
            end
        endcase
    end

    assign step_idx = step_reg;
    assign man_drop = drop_reg;

endmodule

// File: tb/tb_alu_demo_sched.sv
// ---------------------------------------------------------------------------
// tb_alu_demo_sched
//
// Self-checking bench for alu_demo_sched (DWELL_TICKS = 3). A cycle task
// drives random operand bits, generates the tick strobe and observes the
// outputs each cycle: every demo load pulse is logged and compared with the
// step table, and WORD/RESULT phase lengths are measured in tick pulses.
// ---------------------------------------------------------------------------
module tb_alu_demo_sched;

    localparam int DW = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       demo;
    logic       man_req;
    logic       man_sub;
    logic       man_rc;
    logic       man_clr;
    logic       d_clr;
    logic       d_en;
    logic       d_sub;
    logic       d_RC;
    logic [2:0] word_sel;
    logic       disp_sel;
    logic       busy;
    logic [1:0] step_idx;
    logic       man_drop;

    int checks   = 0;
    int failures = 0;

    int tick_period = 5;
    int tick_ctr    = 0;
    int clr_cnt     = 0;

    // observation state
    logic pre_disp  = 1'b0;
    logic pre_tick  = 1'b0;
    logic pre_en    = 1'b0;
    logic pre_clr   = 1'b0;
    logic pre_exec  = 1'b0;
    logic cur_exec  = 1'b0;
    logic res_phase = 1'b0;
    int   word_ticks = 0;
    int   res_ticks  = 0;
    logic [3:0] demo_q[$];   // {step_idx, d_sub, d_RC} at each demo load

    wire [11:0] all_outs = {d_clr, d_en, d_sub, d_RC, word_sel, disp_sel,
                            busy, step_idx, man_drop};

    always #5 clk = ~clk;

    alu_demo_sched #(.DWELL_TICKS(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .demo     (demo),
        .man_req  (man_req),
        .man_sub  (man_sub),
        .man_rc   (man_rc),
        .man_clr  (man_clr),
        .d_clr    (d_clr),
        .d_en     (d_en),
        .d_sub    (d_sub),
        .d_RC     (d_RC),
        .word_sel (word_sel),
        .disp_sel (disp_sel),
        .busy     (busy),
        .step_idx (step_idx),
        .man_drop (man_drop)
    );

    // Reference step table: step k loads with sub = odd step, rc = first two.
    function automatic logic [3:0] ref_step(input int k);
        logic [1:0] s;
        s = 2'(k);
        return {s, 1'(k % 2), (k < 2)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: capture pre-edge view, advance, randomize the
    // operand bits, then observe the new cycle's outputs.
    task automatic cyc();
        if (tick && disp_sel)  word_ticks++;
        if (tick && res_phase) res_ticks++;
        pre_disp = disp_sel;
        pre_tick = tick;
        pre_en   = d_en;
        pre_clr  = d_clr;
        pre_exec = cur_exec;
        @(posedge clk);
        #1;
        man_req = 1'b0;
        man_clr = 1'b0;
        man_sub = 1'($urandom);
        man_rc  = 1'($urandom);
        #1;
        cur_exec = 1'b0;
        if (d_en) begin
            chk("en_single_cycle", pre_en, 0);
            $display("t=%0t load sub=%0b rc=%0b step=%0d", $time, d_sub, d_RC, step_idx);
        end
        if (d_clr) begin
            clr_cnt++;
            chk("clr_single_cycle", pre_clr, 0);
            $display("t=%0t clear", $time);
        end
        if (pre_disp && !disp_sel) begin
            if (d_en) begin
                chk("word_ticks", word_ticks, DW);
                chk("word_exit_on_tick", pre_tick, 1);
                demo_q.push_back({step_idx, d_sub, d_RC});
                cur_exec = 1'b1;
            end
            word_ticks = 0;
        end
        if (!pre_disp && disp_sel) begin
            if (res_phase) chk("result_ticks", res_ticks, DW);
            res_phase  = 1'b0;
            word_ticks = 0;
        end
        if (pre_exec && step_idx != 2'd3) begin
            res_phase = 1'b1;
            res_ticks = 0;
        end
        if (d_clr || !busy) res_phase = 1'b0;
        tick_ctr++;
        tick = (tick_ctr % tick_period) == 0;
    endtask

    initial begin
        int   base;
        int   n;
        logic s;
        logic r;

        reset = 1'b1; tick = 1'b0; demo = 1'b1;
        man_req = 1'b0; man_sub = 1'b0; man_rc = 1'b0; man_clr = 1'b0;

        // ---- reset with demo held, then a full pass --------------------
        tick_period = 5;
        repeat (3) cyc();
        chk("reset_outputs", all_outs, 0);
        reset = 1'b0;
        cyc();
        chk("start_clr", d_clr, 1);
        chk("start_busy", busy, 1);
        cyc();
        chk("start_word_disp", disp_sel, 1);
        chk("start_word_sel", word_sel, 0);
        chk("start_word_rc", d_RC, 1);
        chk("start_word_sub", d_sub, 0);
        chk("start_word_noclr", d_clr, 0);
        for (int i = 0; i < 600 && demo_q.size() < 4; i++) cyc();
        chk("pass_load_count", demo_q.size(), 4);
        for (int k = 0; k < demo_q.size(); k++) chk("pass_step", demo_q[k], ref_step(k));
`ifdef ALU_DEMO_SCHED_LOOP_EN
        for (int i = 0; i < 200 && !d_clr; i++) cyc();
        chk("loop_clr", d_clr, 1);
        chk("loop_step0", step_idx, 0);
        cyc();
        chk("loop_word_disp", disp_sel, 1);
        chk("loop_word_sel", word_sel, 0);
`else
        for (int i = 0; i < 200 && !(busy && !d_sub && !d_en && step_idx == 2'd3); i++) cyc();
        chk("done_busy", busy, 1);
        chk("done_step", step_idx, 3);
        chk("done_disp", disp_sel, 0);
        base = clr_cnt;
        repeat (20) cyc();
        chk("done_hold_busy", busy, 1);
        chk("done_hold_noclr", clr_cnt, base);
`endif
        demo = 1'b0;
        cyc();
        chk("end_clr", d_clr, 1);
        cyc();
        chk("end_busy", busy, 0);
        chk("end_step", step_idx, 0);

        // ---- manual operations -----------------------------------------
        tick_period = $urandom_range(1, 6);
        for (int t = 0; t < 8; t++) begin
            s = (t == 0) ? 1'b1 : 1'($urandom);
            r = (t == 0) ? 1'b0 : 1'($urandom);
            base = clr_cnt;
            man_req = 1'b1; man_sub = s; man_rc = r;
            cyc();
            chk("man_en", d_en, 1);
            chk("man_sub", d_sub, s);
            chk("man_rc", d_RC, r);
            chk("man_busy", busy, 1);
            cyc();
            chk("man_idle_busy", busy, 0);
            chk("man_idle_en", d_en, 0);
            chk("man_no_clr", clr_cnt, base);
            n = $urandom_range(0, 3);
            repeat (n) cyc();
        end

        // ---- arbitration in IDLE ---------------------------------------
        man_req = 1'b1; man_clr = 1'b1;
        cyc();
        chk("arb_clr", d_clr, 1);
        chk("arb_no_en", d_en, 0);
        chk("arb_drop", man_drop, 1);
        cyc();
        chk("arb_drop_pulse", man_drop, 0);
        chk("arb_idle", busy, 0);
        chk("arb_still_no_en", d_en, 0);
        demo_q.delete();
        tick_period = $urandom_range(1, 6);
        demo = 1'b1; man_req = 1'b1;
        cyc();
        chk("demo_wins_clr", d_clr, 1);
        chk("demo_wins_drop", man_drop, 1);

        // ---- manual request during WORD, abort in step 2 RESULT -------
        for (int i = 0; i < 50 && !disp_sel; i++) cyc();
        chk("reach_word", disp_sel, 1);
        man_req = 1'b1;
        cyc();
        chk("word_req_drop", man_drop, 1);
        chk("word_req_no_en", d_en, 0);
        chk("word_req_disp", disp_sel, 1);
        for (int i = 0; i < 600 && demo_q.size() < 3; i++) cyc();
        chk("abort_load_count", demo_q.size(), 3);
        for (int k = 0; k < demo_q.size(); k++) chk("abort_step", demo_q[k], ref_step(k));
        cyc();
        chk("res2_disp", disp_sel, 0);
        chk("res2_en", d_en, 0);
        chk("res2_step", step_idx, 2);
        chk("res2_busy", busy, 1);
        demo = 1'b0;
        cyc();
        chk("res2_abort_clr", d_clr, 1);
        cyc();
        chk("res2_abort_idle", busy, 0);
        chk("res2_abort_step", step_idx, 0);
        repeat (10) cyc();
        chk("res2_no_more_loads", demo_q.size(), 3);

        // ---- random abort points ---------------------------------------
        for (int t = 0; t < 5; t++) begin
            demo_q.delete();
            tick_period = $urandom_range(1, 6);
            demo = 1'b1;
            n = $urandom_range(3, 150);
            repeat (n) cyc();
            base = clr_cnt;
            demo = 1'b0;
            for (int i = 0; i < 4 && (busy || i == 0); i++) cyc();
            chk("rand_abort_idle", busy, 0);
            chk("rand_abort_step", step_idx, 0);
            chk("rand_abort_one_clr", clr_cnt, base + 1);
            for (int k = 0; k < demo_q.size(); k++) chk("rand_step", demo_q[k], ref_step(k % 4));
            repeat (3) cyc();
        end

        // ---- reset mid-sequence ----------------------------------------
        demo_q.delete();
        tick_period = 2;
        demo = 1'b1;
        for (int i = 0; i < 200 && demo_q.size() < 1; i++) cyc();
        chk("mid_reach_exec", demo_q.size(), 1);
        reset = 1'b1; man_req = 1'b1; man_clr = 1'b1;
        cyc();
        chk("mid_reset_outputs", all_outs, 0);
        reset = 1'b0; demo = 1'b0;
        cyc();
        chk("post_reset_idle", all_outs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
